// File: rtl/beam_pwr_select.sv
// beam_pwr_select: per-beam |x|^2 accumulated over a block of REs, then a sequential argmax.
// Optional macro BEAM_PWR_SAT_EN: accumulators saturate at 2^AW-1 instead of wrapping.
module beam_pwr_select #(
    parameter int BEAM  = 16,
    parameter int IW    = 32,
    parameter int AW    = 48,
    parameter int LEN_W = 12
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [BEAM-1:0][IW-1:0]      i_sum_data,
    input  logic                         i_tvalid,
    input  logic                         i_sop,
    input  logic [LEN_W-1:0]             i_acc_len,
    output logic [BEAM-1:0][AW-1:0]      o_beam_pwr,
    output logic [$clog2(BEAM)-1:0]      o_max_idx,
    output logic [AW-1:0]                o_max_pwr,
    output logic                         o_tvalid,
    output logic                         o_busy,
    output logic                         o_drop
);
    localparam int IDX_W  = $clog2(BEAM);
    localparam int IDX_W1 = IDX_W + 1;
    localparam int HW     = IW / 2;
    localparam logic [IDX_W:0]   IDX_END = IDX_W1'(BEAM);
    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEARCH = 2'd1, S_DONE = 2'd2} state_t;

    function automatic logic [IW-1:0] cpow(input logic [IW-1:0] x);
        logic signed [HW-1:0] re;
        logic signed [HW-1:0] im;
        logic signed [IW-1:0] re2;
        logic signed [IW-1:0] im2;
        re  = x[HW-1:0];
        im  = x[IW-1:HW];
        re2 = IW'(re) * IW'(re);
        im2 = IW'(im) * IW'(im);
        return $unsigned(re2) + $unsigned(im2);
    endfunction

    function automatic logic [AW-1:0] acc_add(input logic [AW-1:0] a, input logic [IW-1:0] p);
`ifdef BEAM_PWR_SAT_EN
        logic [AW:0] s;
        s = {1'b0, a} + {1'b0, AW'(p)};
        return s[AW] ? {AW{1'b1}} : s[AW-1:0];
`else
        return a + AW'(p);
`endif
    endfunction

    logic [BEAM-1:0][IW-1:0] r_p;
    logic                    r_pv;
    logic                    r_psop;
    logic [LEN_W-1:0]        r_plen;
    logic [BEAM-1:0][AW-1:0] r_acc;
    logic                    r_active;
    logic [LEN_W-1:0]        r_cnt;
    logic [LEN_W-1:0]        r_len;
    logic                    r_blk_cmp;
    logic [BEAM-1:0][AW-1:0] r_snap;
    state_t                  r_state;
    logic [IDX_W:0]          r_idx;
    logic [IDX_W-1:0]        r_best_idx;
    logic [AW-1:0]           r_best_pwr;
    logic [BEAM-1:0][AW-1:0] r_beam_pwr;
    logic [IDX_W-1:0]        r_max_idx;
    logic [AW-1:0]           r_max_pwr;
    logic                    r_tvalid;
    logic                    r_busy;
    logic                    r_drop;
    logic [LEN_W-1:0]        w_len_new;
    logic [LEN_W-1:0]        w_cnt_inc;

    // A zero block length is treated as a one-sample block.
    always_comb begin
        w_len_new = r_plen;
        if (r_plen == {LEN_W{1'b0}}) begin
            w_len_new = LEN_ONE;
        end else begin
            w_len_new = r_plen;
        end
        w_cnt_inc = r_cnt + LEN_ONE;
    end

    // Power stage: one register of |x|^2 per beam plus aligned valid/sop/len.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_p    <= '0;
            r_pv   <= 1'b0;
            r_psop <= 1'b0;
            r_plen <= '0;
        end else begin
            r_pv   <= i_tvalid;
            r_psop <= i_tvalid & i_sop;
            r_plen <= i_acc_len;
            if (i_tvalid) begin
                for (int b = 0; b < BEAM; b++) begin
                    r_p[b] <= cpow(i_sum_data[b]);
                end
            end
        end
    end

    // Accumulate side; r_blk_cmp pulses the cycle after the last sample is added.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_acc     <= '0;
            r_active  <= 1'b0;
            r_cnt     <= '0;
            r_len     <= '0;
            r_blk_cmp <= 1'b0;
        end else begin
            r_blk_cmp <= 1'b0;
            if (r_pv && r_psop) begin
                for (int b = 0; b < BEAM; b++) begin
                    r_acc[b] <= AW'(r_p[b]);
                end
                r_cnt <= LEN_ONE;
                r_len <= w_len_new;
                if (w_len_new == LEN_ONE) begin
                    r_blk_cmp <= 1'b1;
                    r_active  <= 1'b0;
                end else begin
                    r_active  <= 1'b1;
                end
            end else if (r_pv && r_active) begin
                for (int b = 0; b < BEAM; b++) begin
                    r_acc[b] <= acc_add(r_acc[b], r_p[b]);
                end
                r_cnt <= w_cnt_inc;
                if (w_cnt_inc == r_len) begin
                    r_blk_cmp <= 1'b1;
                    r_active  <= 1'b0;
                end
            end
        end
    end

    // Search FSM: snapshot, one compare per cycle, then publish. A completion seen in DONE restarts directly.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_snap     <= '0;
            r_idx      <= '0;
            r_best_idx <= '0;
            r_best_pwr <= '0;
            r_beam_pwr <= '0;
            r_max_idx  <= '0;
            r_max_pwr  <= '0;
            r_tvalid   <= 1'b0;
            r_busy     <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_tvalid <= 1'b0;
            r_drop   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                end
                S_SEARCH: begin
                    r_drop <= r_blk_cmp;
                    if (r_idx == IDX_END) begin
                        r_state <= S_DONE;
                    end else begin
                        if (r_snap[r_idx[IDX_W-1:0]] > r_best_pwr) begin
                            r_best_idx <= r_idx[IDX_W-1:0];
                            r_best_pwr <= r_snap[r_idx[IDX_W-1:0]];
                        end
                        r_idx <= r_idx + {{IDX_W{1'b0}}, 1'b1};
                    end
                end
                S_DONE: begin
                    r_beam_pwr <= r_snap;
                    r_max_idx  <= r_best_idx;
                    r_max_pwr  <= r_best_pwr;
                    r_tvalid   <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            if (r_blk_cmp && (r_state == S_IDLE || r_state == S_DONE)) begin
                r_snap     <= r_acc;
                r_best_idx <= '0;
                r_best_pwr <= r_acc[0];
                r_idx      <= {{IDX_W{1'b0}}, 1'b1};
                r_state    <= S_SEARCH;
                r_busy     <= 1'b1;
            end
        end
    end

    assign o_beam_pwr = r_beam_pwr;
    assign o_max_idx  = r_max_idx;
    assign o_max_pwr  = r_max_pwr;
    assign o_tvalid   = r_tvalid;
    assign o_busy     = r_busy;
    assign o_drop     = r_drop;
endmodule

// File: tb/tb_beam_pwr_select.sv
// Directed table-driven bench for beam_pwr_select, plus a narrow-accumulator instance for wrap/saturate.
module tb_beam_pwr_select;
    localparam int BEAM = 16, IW = 32, AW = 48, AWS = 34, LEN_W = 12, IDX_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_n;
    logic [BEAM-1:0][IW-1:0] sum_data;
    logic                    tvalid, sop;
    logic [LEN_W-1:0]        acc_len;

    logic [BEAM-1:0][AW-1:0] o_beam_pwr;
    logic [IDX_W-1:0]        o_max_idx;
    logic [AW-1:0]           o_max_pwr;
    logic                    o_tvalid, o_busy, o_drop;

    logic [BEAM-1:0][AWS-1:0] s_beam_pwr;
    logic [IDX_W-1:0]         s_max_idx;
    logic [AWS-1:0]           s_max_pwr;
    logic                     s_tvalid, s_busy, s_drop;

    beam_pwr_select #(.BEAM(BEAM), .IW(IW), .AW(AW), .LEN_W(LEN_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sum_data(sum_data), .i_tvalid(tvalid),
        .i_sop(sop), .i_acc_len(acc_len), .o_beam_pwr(o_beam_pwr), .o_max_idx(o_max_idx),
        .o_max_pwr(o_max_pwr), .o_tvalid(o_tvalid), .o_busy(o_busy), .o_drop(o_drop));

    beam_pwr_select #(.BEAM(BEAM), .IW(IW), .AW(AWS), .LEN_W(LEN_W)) dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_sum_data(sum_data), .i_tvalid(tvalid),
        .i_sop(sop), .i_acc_len(acc_len), .o_beam_pwr(s_beam_pwr), .o_max_idx(s_max_idx),
        .o_max_pwr(s_max_pwr), .o_tvalid(s_tvalid), .o_busy(s_busy), .o_drop(s_drop));

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        int     len;
        int     ia, ra, ima;
        int     ib, rb, imb;
        int     ro, imo;
        int     e_idx;
        longint e_a, e_b, e_o, e_max;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] pk(input int re, input int im);
        logic [15:0] r;
        logic [15:0] i;
        r = 16'(re);
        i = 16'(im);
        return {i, r};
    endfunction

    task automatic fill(input int re, input int im);
        for (int b = 0; b < BEAM; b++) sum_data[b] = pk(re, im);
    endtask

    task automatic send(input logic s, input int l);
        sop = s; acc_len = LEN_W'(l); tvalid = 1'b1;
        @(posedge clk); #1;
        tvalid = 1'b0; sop = 1'b0;
    endtask

    task automatic wait_out(input int budget, output int lat, output int n_tv, output int n_dr);
        lat = -1; n_tv = 0; n_dr = 0;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk); #1;
            if (o_tvalid) begin
                n_tv++;
                if (lat < 0) lat = c;
            end
            if (o_drop) n_dr++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat, ntv, ndr, nsamp;
        longint e;
        for (int b = 0; b < BEAM; b++) begin
            if (b == v.ia)      sum_data[b] = pk(v.ra, v.ima);
            else if (b == v.ib) sum_data[b] = pk(v.rb, v.imb);
            else                sum_data[b] = pk(v.ro, v.imo);
        end
        nsamp = (v.len < 1) ? 1 : v.len;
        for (int k = 0; k < nsamp; k++) send(k == 0, v.len);
        wait_out(25, lat, ntv, ndr);
        chk({tag, " latency"}, 64'(lat), 64'd19);
        chk({tag, " tvalid_count"}, 64'(ntv), 64'd1);
        chk({tag, " drop_count"}, 64'(ndr), 64'd0);
        for (int b = 0; b < BEAM; b++) begin
            e = (b == v.ia) ? v.e_a : (b == v.ib) ? v.e_b : v.e_o;
            chk($sformatf("%s beam_pwr[%0d]", tag, b), 64'(o_beam_pwr[b]), 64'(e));
        end
        chk({tag, " max_idx"}, 64'(o_max_idx), 64'(v.e_idx));
        chk({tag, " max_pwr"}, 64'(o_max_pwr), 64'(v.e_max));
        chk({tag, " busy_idle"}, 64'(o_busy), 64'd0);
    endtask

    initial begin
        int lat, ntv, ndr;
        longint sat_exp;
        vt[0] = '{len:4, ia:5, ra:100, ima:0, ib:5, rb:100, imb:0, ro:10, imo:10,
                  e_idx:5, e_a:40000, e_b:40000, e_o:800, e_max:40000};
        vt[1] = '{len:2, ia:3, ra:50, ima:50, ib:9, rb:50, imb:50, ro:0, imo:0,
                  e_idx:3, e_a:10000, e_b:10000, e_o:0, e_max:10000};
        vt[2] = '{len:0, ia:7, ra:-3, ima:4, ib:7, rb:-3, imb:4, ro:1, imo:-1,
                  e_idx:7, e_a:25, e_b:25, e_o:2, e_max:25};
        vt[3] = '{len:3, ia:0, ra:-5, ima:-5, ib:0, rb:-5, imb:-5, ro:-5, imo:-5,
                  e_idx:0, e_a:150, e_b:150, e_o:150, e_max:150};
        vt[4] = '{len:1, ia:15, ra:0, ima:-200, ib:2, rb:-100, imb:100, ro:100, imo:-100,
                  e_idx:15, e_a:40000, e_b:20000, e_o:20000, e_max:40000};
        vt[5] = '{len:5, ia:8, ra:3, ima:4, ib:12, rb:4, imb:3, ro:0, imo:1,
                  e_idx:8, e_a:125, e_b:125, e_o:5, e_max:125};

        rst_n = 1'b0; tvalid = 1'b0; sop = 1'b0; acc_len = '0; fill(0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset beam_pwr[0]", 64'(o_beam_pwr[0]), 64'd0);
        chk("reset max_idx", 64'(o_max_idx), 64'd0);
        chk("reset max_pwr", 64'(o_max_pwr), 64'd0);
        chk("reset tvalid", 64'(o_tvalid), 64'd0);
        chk("reset busy", 64'(o_busy), 64'd0);
        chk("reset drop", 64'(o_drop), 64'd0);
        rst_n = 1'b1;

        // Samples before the first sop are ignored
        fill(300, 300);
        for (int k = 0; k < 4; k++) send(1'b0, 2);
        wait_out(25, lat, ntv, ndr);
        chk("pre_sop tvalid_count", 64'(ntv), 64'd0);

        for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // sop mid-block restarts silently
        fill(7, 7);
        send(1'b1, 4); send(1'b0, 4);
        fill(1, 0);
        send(1'b1, 4);
        for (int k = 0; k < 3; k++) send(1'b0, 4);
        wait_out(25, lat, ntv, ndr);
        chk("restart latency", 64'(lat), 64'd19);
        chk("restart drop_count", 64'(ndr), 64'd0);
        chk("restart beam_pwr[0]", 64'(o_beam_pwr[0]), 64'd4);
        chk("restart beam_pwr[15]", 64'(o_beam_pwr[15]), 64'd4);
        chk("restart max_pwr", 64'(o_max_pwr), 64'd4);

        // Back-to-back blocks: second completes mid-search and is dropped
        fill(2, 0);
        for (int k = 0; k < 4; k++) send(k == 0, 4);
        fill(3, 0);
        for (int k = 0; k < 4; k++) send(k == 0, 4);
        wait_out(40, lat, ntv, ndr);
        chk("b2b latency", 64'(lat), 64'd15);
        chk("b2b tvalid_count", 64'(ntv), 64'd1);
        chk("b2b drop_count", 64'(ndr), 64'd1);
        chk("b2b beam_pwr[0]", 64'(o_beam_pwr[0]), 64'd16);

        // Full-scale input: wraps at 2^34 unless saturation is enabled
`ifdef BEAM_PWR_SAT_EN
        sat_exp = 64'h3_FFFF_FFFF;
`else
        sat_exp = 0;
`endif
        fill(-32768, -32768);
        for (int k = 0; k < 8; k++) send(k == 0, 8);
        wait_out(25, lat, ntv, ndr);
        chk("full48 latency", 64'(lat), 64'd19);
        chk("full48 beam_pwr[3]", 64'(o_beam_pwr[3]), 64'h4_0000_0000);
        chk("aw34 tvalid", 64'(ntv), 64'd1);
        chk("aw34 beam_pwr[0]", 64'(s_beam_pwr[0]), 64'(sat_exp));
        chk("aw34 beam_pwr[15]", 64'(s_beam_pwr[15]), 64'(sat_exp));
        chk("aw34 max_pwr", 64'(s_max_pwr), 64'(sat_exp));
        chk("aw34 max_idx", 64'(s_max_idx), 64'd0);

        // Reset during SEARCH aborts and clears
        fill(9, 9);
        send(1'b1, 1);
        repeat (6) @(posedge clk);
        #1;
        chk("midsearch busy_before", 64'(o_busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midsearch beam_pwr[3]", 64'(o_beam_pwr[3]), 64'd0);
        chk("midsearch max_pwr", 64'(o_max_pwr), 64'd0);
        chk("midsearch busy", 64'(o_busy), 64'd0);
        wait_out(30, lat, ntv, ndr);
        chk("midsearch tvalid_count", 64'(ntv), 64'd0);
        run_vec(vt[0], "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
